// File: rtl/vreg_element_seq.sv
// Vector register file with an element-serial sequencer: streams two source
// vectors to the x1/x2 temp registers and writes ALU results back element by element.
module vreg_element_seq #(
    parameter int NUM_VREGS = 4,
    parameter int ELEMS     = 4,
    parameter int DATA_W    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ld_en,
    input  logic [$clog2(NUM_VREGS)-1:0] ld_reg,
    input  logic [$clog2(ELEMS)-1:0]     ld_elem,
    input  logic [DATA_W-1:0]            ld_data,
    input  logic                         start,
    input  logic [$clog2(NUM_VREGS)-1:0] vra,
    input  logic [$clog2(NUM_VREGS)-1:0] vrb,
    input  logic [$clog2(NUM_VREGS)-1:0] vrw,
    input  logic                         wb_en,
    input  logic                         wb_valid,
    input  logic [DATA_W-1:0]            wb_data,
    output logic [DATA_W-1:0]            x1_data,
    output logic [DATA_W-1:0]            x2_data,
    output logic                         x_write,
    output logic [$clog2(ELEMS)-1:0]     elem_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         wb_err
);

    localparam int AW = $clog2(NUM_VREGS);
    localparam int EW = $clog2(ELEMS);
    localparam int CW = EW + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   vmem [NUM_VREGS][ELEMS];
    logic [AW-1:0]       vra_q, vrb_q, vrw_q;
    logic                wb_en_q;
    logic [CW-1:0]       rd_cnt, wb_cnt;

    logic                start_ok, load_ok, read_next, wb_acc, wb_bad, wb_last, finish;
    logic [EW-1:0]       elem_nx;
    logic [DATA_W-1:0]   x1_first, x2_first;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        load_ok   = 1'b0;
        read_next = 1'b0;
        wb_acc    = 1'b0;
        wb_bad    = 1'b0;
        wb_last   = 1'b0;
        finish    = 1'b0;
        elem_nx   = elem_idx + 1'b1;
        // A same-edge load into element 0 of a source must be seen by the first read
        x1_first  = vmem[vra][0];
        x2_first  = vmem[vrb][0];
        if (ld_en && ld_reg == vra && ld_elem == '0) x1_first = ld_data;
        if (ld_en && ld_reg == vrb && ld_elem == '0) x2_first = ld_data;

        if (state == S_IDLE) begin
            load_ok = ld_en;
            wb_bad  = wb_valid;
            if (start) begin
                start_ok = 1'b1;
                state_nx = S_READ;
            end
        end else begin
            if (wb_valid && wb_en_q) begin
                if (wb_cnt < rd_cnt) wb_acc = 1'b1;
                else                 wb_bad = 1'b1;
            end
            wb_last = wb_acc && (wb_cnt == CW'(ELEMS - 1));
            if (state == S_READ) begin
                if (elem_idx == EW'(ELEMS - 1)) begin
                    if (!wb_en_q || wb_last) begin
                        finish   = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_DRAIN;
                    end
                end else begin
                    read_next = 1'b1;
                end
            end else if (wb_last) begin
                finish   = 1'b1;
                state_nx = S_IDLE;
            end
        end
    end

    // Issue stage: element reads, write-back and status registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_VREGS; r++)
                for (int e = 0; e < ELEMS; e++)
                    vmem[r][e] <= '0;
            vra_q    <= '0;
            vrb_q    <= '0;
            vrw_q    <= '0;
            wb_en_q  <= 1'b0;
            rd_cnt   <= '0;
            wb_cnt   <= '0;
            x1_data  <= '0;
            x2_data  <= '0;
            x_write  <= 1'b0;
            elem_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wb_err   <= 1'b0;
        end else begin
            x_write <= start_ok | read_next;
            busy    <= (state_nx != S_IDLE);
            done    <= finish;
            if (load_ok) vmem[ld_reg][ld_elem] <= ld_data;
            if (start_ok) begin
                vra_q    <= vra;
                vrb_q    <= vrb;
                vrw_q    <= vrw;
                wb_en_q  <= wb_en;
                x1_data  <= x1_first;
                x2_data  <= x2_first;
                elem_idx <= '0;
                rd_cnt   <= CW'(1);
                wb_cnt   <= '0;
                wb_err   <= wb_bad;
            end else begin
                if (wb_bad) wb_err <= 1'b1;
                if (read_next) begin
                    elem_idx <= elem_nx;
                    x1_data  <= vmem[vra_q][elem_nx];
                    x2_data  <= vmem[vrb_q][elem_nx];
                    rd_cnt   <= rd_cnt + 1'b1;
                end
                if (wb_acc) begin
                    vmem[vrw_q][wb_cnt[EW-1:0]] <= wb_data;
                    wb_cnt <= wb_cnt + 1'b1;
                end
            end
        end
    end

endmodule
